// File: rtl/scale_apply.sv
// scale_apply: two-stage pipeline that multiplies a Q-format operand by a late-arriving scale,
// rounding half up and saturating to the data width (mode 00 passes the operand through).
module scale_apply #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        gemm_uno,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MUL_BW-1:0] m_i,
    input  logic [MUL_BW-1:0] scale_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MUL_BW-1:0] res_o,
    output logic              sat_o,
    input  logic              sat_clr,
    output logic [15:0]       sat_cnt
);
    localparam int PW = 2 * MUL_BW;
    localparam logic [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (FRA_BW - 1);

    logic              s0_v, s0_cap, s1_v;
    logic [1:0]        s0_mode;
    logic [MUL_BW-1:0] s0_m, s0_scale, sc, res_n;
    logic signed [PW-1:0] prod, rnd, r;
    logic              adv1, mv, ld, ovf, sat_n;

    assign adv1      = ~s1_v | out_ready;
    assign in_ready  = ~s0_v | adv1;
    assign mv        = s0_v & adv1;
    assign ld        = in_valid & in_ready;
    assign out_valid = s1_v;

    // The scale arrives one cycle after acceptance; a stalled beat keeps the captured copy.
    always_comb begin
        sc    = s0_cap ? s0_scale : scale_i;
        prod  = $signed(sc) * $signed(s0_m);
        rnd   = prod + $signed(HALF);
        r     = rnd >>> FRA_BW;
        ovf   = ~(&r[PW-1:INT_BW+FRA_BW] | ~|r[PW-1:INT_BW+FRA_BW]);
        res_n = s0_mode == 2'b00 ? s0_m
              : ovf ? (r[PW-1] ? {1'b1, {(MUL_BW-1){1'b0}}} : {1'b0, {(MUL_BW-1){1'b1}}})
              : r[MUL_BW-1:0];
        sat_n = s0_mode != 2'b00 && ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v     <= 1'b0;
            s0_cap   <= 1'b0;
            s0_mode  <= '0;
            s0_m     <= '0;
            s0_scale <= '0;
        end else if (ld) begin
            s0_v    <= 1'b1;
            s0_cap  <= 1'b0;
            s0_mode <= gemm_uno;
            s0_m    <= m_i;
        end else if (mv) begin
            s0_v   <= 1'b0;
            s0_cap <= 1'b0;
        end else if (s0_v && !s0_cap) begin
            s0_scale <= scale_i;
            s0_cap   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            res_o <= '0;
            sat_o <= 1'b0;
        end else if (adv1) begin
            s1_v <= s0_v;
            if (s0_v) begin
                res_o <= res_n;
                sat_o <= sat_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (s1_v && out_ready && sat_o && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
endmodule

// File: tb/tb_scale_apply.sv
// tb_scale_apply: directed vectors with hand-computed results for scale_apply.
module tb_scale_apply;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  gemm_uno = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] m_i = '0;
    logic [15:0] scale_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] res_o;
    logic        sat_o;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_cnt;
    int          errors = 0;
    int          checks = 0;

    scale_apply dut (
        .clk(clk), .rst_n(rst_n), .gemm_uno(gemm_uno), .in_valid(in_valid),
        .in_ready(in_ready), .m_i(m_i), .scale_i(scale_i), .out_valid(out_valid),
        .out_ready(out_ready), .res_o(res_o), .sat_o(sat_o), .sat_clr(sat_clr),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one beat, present its scale a cycle later, scramble inputs, check 2-cycle latency.
    task automatic beat(input string tag, input logic [1:0] mode, input logic [15:0] m,
                        input logic [15:0] s, input logic [15:0] er, input logic es);
        in_valid = 1'b1;
        gemm_uno = mode;
        m_i      = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scale_i  = s;
        m_i      = ~m;
        gemm_uno = ~mode;
        check({tag, "_ov0"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        scale_i = 16'h5555;
        check({tag, "_ov1"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, {16'd0, res_o}, {16'd0, er});
        check({tag, "_sat"}, {31'd0, sat_o}, {31'd0, es});
    endtask

    initial begin
        int idx, got;
        logic acc;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        check("rst_res", {16'd0, res_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        beat("exp3x1", 2'b10, 16'h0C00, 16'h0400, 16'h0C00, 1'b0);
        beat("div_max", 2'b01, 16'h7FFF, 16'h2B80, 16'h7FFF, 1'b1);
        @(posedge clk); #1;
        check("cnt_one", {16'd0, sat_cnt}, 32'd1);
        beat("div_min", 2'b01, 16'h8000, 16'h2B80, 16'h8000, 1'b1);
        beat("log_neg", 2'b11, 16'h0400, 16'hFC00, 16'hFC00, 1'b0);
        beat("div_rnd", 2'b01, 16'h0200, 16'h0001, 16'h0001, 1'b0);
        beat("gemm", 2'b00, 16'h8000, 16'h1234, 16'h8000, 1'b0);
        @(posedge clk); #1;
        check("cnt_two", {16'd0, sat_cnt}, 32'd2);

        // 8-beat stream, stalled cycles 4..6; scale driven to 0 after the stalled beat captured it
        idx = 0;
        got = 0;
        gemm_uno = 2'b01;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = idx < 8;
            m_i       = 16'((idx + 1) << 10);
            out_ready = !(cyc >= 4 && cyc <= 6);
            scale_i   = (cyc >= 5 && cyc <= 7) ? 16'h0000 : 16'h0400;
            #1;
            check("strm_in_ready", {31'd0, in_ready}, (cyc >= 4 && cyc <= 6) ? 32'd0 : 32'd1);
            if (out_valid) begin
                check(out_ready ? "strm_res" : "strm_hold", {16'd0, res_o}, 32'((got + 1) << 10));
                if (out_ready) got++;
            end
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("strm_count", 32'(got), 32'd8);

        // async reset while both stages hold beats
        out_ready = 1'b0;
        gemm_uno  = 2'b01;
        m_i       = 16'h7FFF;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        scale_i = 16'h2B80;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ov", {31'd0, out_valid}, 32'd0);
        beat("post_rst", 2'b10, 16'h0C00, 16'h0400, 16'h0C00, 1'b0);

        // saturate the counter, then clear during a saturating handshake
        gemm_uno = 2'b01;
        m_i      = 16'h7FFF;
        scale_i  = 16'h2B80;
        in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        check("cnt_max", {16'd0, sat_cnt}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_stay", {16'd0, sat_cnt}, 32'h0000FFFF);
        check("clr_hs", {30'd0, out_valid, sat_o}, 32'd3);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check("cnt_clr", {16'd0, sat_cnt}, 32'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scale_apply.md
SCALE_APPLY -- requirements
Module: scale_apply

Interface
REQ-001 Parameters SHALL be: INT_BW, default 5, integer bits of the Q format; FRA_BW, default 10, fraction bits; MUL_BW, default 16, data width (INT_BW+FRA_BW+1 = MUL_BW).
REQ-002 Ports SHALL be, in order:
  clk  in  1  clock, rising edge.
  rst_n  in  1  asynchronous reset, active low.
  gemm_uno  in  2  mode of the input beat: 00 gemm, 01 div, 10 exp, 11 log.
  in_valid  in  1  input beat valid.
  in_ready  out  1  block accepts the beat this cycle.
  m_i  in  MUL_BW  signed operand of the beat.
  scale_i  in  MUL_BW  signed scale from the scale generator; valid one cycle after beat acceptance.
  out_valid  out  1  result valid.
  out_ready  in  1  downstream accepts the result.
  res_o  out  MUL_BW  signed result.
  sat_o  out  1  result of the current beat was saturated.
  sat_clr  in  1  synchronous clear of sat_cnt.
  sat_cnt  out  16  count of saturated beats delivered.
REQ-003 One clock, clk; reset rst_n is asynchronous, active low.

Function
REQ-004 A beat SHALL be accepted on a rising edge when in_valid && in_ready.
REQ-005 Pipeline SHALL be two stages: S0 (m, mode, scale hold, scale-captured flag, valid) and S1 (res, sat, valid); out_valid = S1 valid.
REQ-006 S1 advance condition SHALL be adv1 = ~S1.valid | out_ready; S0 moves to S1 on an edge where S0.valid && adv1.
REQ-007 in_ready SHALL be ~S0.valid | adv1 (combinational; full throughput of one beat per cycle with out_ready high).
REQ-008 Scale used for an S0 beat SHALL be live scale_i in the first cycle after its load, and S0.scale_hold thereafter; S0 SHALL latch scale_i and set the captured flag at the end of that first cycle if it does not advance.
REQ-009 Latency SHALL be 2 cycles: beat accepted at edge E SHALL appear with out_valid high after edge E+1, absent stall.
REQ-010 Mode 00 SHALL pass res = m unchanged with sat = 0; scale_i ignored.
REQ-011 Modes 01, 10, 11 SHALL compute p = scale * m as a 2*MUL_BW signed product, then r = (p + 2^(FRA_BW-1)) >>> FRA_BW (arithmetic, round half up).
REQ-012 r SHALL saturate to [-2^(MUL_BW-1), 2^(MUL_BW-1)-1]; sat = 1 iff clipping occurred.
REQ-013 res_o, sat_o SHALL be held stable while out_valid && ~out_ready.
REQ-014 sat_cnt SHALL increment on each out_valid && out_ready && sat_o handshake and saturate at 0xFFFF (no wrap).
REQ-015 sat_clr SHALL zero sat_cnt on the next edge and take priority over a simultaneous increment.
REQ-016 Simultaneous load of S0 and S0→S1 transfer SHALL be supported; the new S0 beat's captured flag SHALL be cleared.
REQ-017 gemm_uno and m_i SHALL be sampled only at acceptance; later changes SHALL not affect the beat.

Reset
REQ-018 On rst_n low, all valid flags, captured flag, res_o, sat_o and sat_cnt SHALL go to 0 immediately; in-flight beats SHALL be discarded.
REQ-019 During and after reset, in_ready SHALL be 1 and out_valid 0.
REQ-020 The first beat after rst_n release SHALL behave as in REQ-009.

Verification
REQ-021 Mode 10, m=0x0C00 (3.0), scale_i=0x0400 (1.0), out_ready=1 -> res_o=0x0C00, sat_o=0, out_valid exactly 2 cycles after acceptance.
REQ-022 Mode 01, m=0x7FFF, scale_i=0x2B80 -> res_o=0x7FFF, sat_o=1, sat_cnt 0->1 on handshake; m=0x8000, scale_i=0x2B80 -> res_o=0x8000, sat_o=1.
REQ-023 Mode 11, m=0x0400, scale_i=0xFC00 (-1.0) -> res_o=0xFC00; mode 01, m=0x0200, scale_i=0x0001 -> res_o=0x0001 (round up); mode 00, m=0x8000, scale_i=0x1234 -> res_o=0x8000, sat_o=0.
REQ-024 Back-to-back 8 beats, out_ready held low 3 cycles mid-stream, scale_i changed to 0x0000 after capture -> no beat lost or duplicated, stalled beat uses captured scale, in_ready low only while both stages full and out_ready low.
REQ-025 rst_n asserted with both stages valid -> out_valid=0, sat_cnt=0 same cycle; sat_cnt forced to 0xFFFF by repeated saturating beats stays 0xFFFF; sat_clr with simultaneous saturating handshake -> sat_cnt=0.
